// File: rtl/rr_arbiter16_if.sv
// Handshake bundle between the 16 requesters and the round-robin arbiter.
// master: requester side (req/done out); slave: arbiter side (gnt/gnt_id/gnt_valid out).
interface rr_arbiter16_if;
   logic [15:0] req;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  gnt_id;
   logic        gnt_valid;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_id,
      input  gnt_valid
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_id,
      output gnt_valid
   );
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot grant and winner index.
// Ports: clk, rst (async active-high), bus (slave: req, done in; gnt, gnt_id, gnt_valid out).
// Optional ARB_TIMEOUT_EN: forced release after HOLD_MAX grant cycles.
module rr_arbiter16 #(
   parameter int HOLD_MAX = 16
) (
   input logic           clk,
   input logic           rst,
   rr_arbiter16_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  gnt_id_q, gnt_id_d;
   logic [15:0] gnt_q, gnt_d;
   logic        gnt_valid_q, gnt_valid_d;

   logic [3:0]  win;
   logic [3:0]  idx;
   logic        any_req;
   logic        timeout_c;
   logic        release_c;

   assign any_req = |bus.req;

   // Walk from ptr+16 (= ptr) down to ptr+1; the last hit wins, so the
   // nearest successor of ptr has priority and ptr itself is checked last.
   always_comb begin
      win = 4'h0;
      idx = 4'h0;
      for (int k = 16; k >= 1; k--) begin
         idx = ptr_q + 4'(k);
         if (bus.req[idx]) begin
            win = idx;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;

   // Counter is zero in the first grant cycle, so hitting HOLD_MAX-1
   // releases after exactly HOLD_MAX cycles.
   assign timeout_c = (state_q == S_GRANT) &&
                      (hold_q == 8'(HOLD_MAX - 1));

   always_comb begin
      hold_d = hold_q;
      if (state_q == S_IDLE) begin
         hold_d = 8'h00;
      end else if (hold_q != 8'hFF) begin
         hold_d = hold_q + 8'h01;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= 8'h00;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   logic [31:0] unused_hold_max;

   assign unused_hold_max = 32'(HOLD_MAX);
   assign timeout_c       = 1'b0;
`endif

   assign release_c = bus.done | ~bus.req[gnt_id_q] | timeout_c;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_id_d    = gnt_id_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d     = S_GRANT;
               ptr_d       = win;
               gnt_id_d    = win;
               gnt_d       = 16'h0001 << win;
               gnt_valid_d = 1'b1;
            end
         end
         S_GRANT: begin
            // gnt_id is kept so downstream muxes still see the last owner.
            if (release_c) begin
               state_d     = S_IDLE;
               gnt_d       = 16'h0000;
               gnt_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= 4'hF;
         gnt_id_q    <= 4'h0;
         gnt_q       <= 16'h0000;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_id_q    <= gnt_id_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

16-way round-robin arbiter that shares one resource among 16 requesters and drives a registered one-hot grant vector, produced by a 4-to-16 decode of the granted index. It sits in front of the 4-to-16 decoder datapath. It sequences which requester owns the shared resource, for how long, and in what order. It also exports the 4-bit winner index so downstream logic can mux data without re-encoding.

## Interface
- HOLD_MAX, 16: maximum grant length in cycles when the timeout feature is compiled in; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request vector; bit i is requester i, level-sensitive.
- done  input  1  release pulse from the current owner; ignored when no grant is active.
- gnt  output  16  one-hot grant, registered; all-zero when idle.
- gnt_id  output  4  index of the current or most recent winner, registered.
- gnt_valid  output  1  high while gnt is non-zero; equals the OR of gnt.

## Operation
- Two-state FSM, IDLE and GRANT, plus a 4-bit priority pointer ptr holding the last winner.
- Reset values:
  - state = IDLE; gnt = 16'h0000; gnt_id = 4'h0; gnt_valid = 0.
  - ptr = 4'hF, so the first search starts at requester 0.
  - Hold counter = 0.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise the winner is the first set bit found searching ptr+1, ptr+2, … with wrap 15→0; ptr itself is checked last.
  - On the next edge: state = GRANT, gnt_id = winner, gnt = 1 << winner, ptr = winner, hold counter cleared.
- GRANT:
  - gnt and gnt_id are held stable.
  - Release occurs when any of the following is true:
    - done == 1;
    - req[gnt_id] == 0;
    - timeout expired (see Configuration).
  - On release, the next edge sets state = IDLE and gnt = 0. gnt_id keeps the last winner.
- Each requester that holds req high is granted within 16 grant cycles (starvation-free).
- Simultaneous events:
  - done together with req[gnt_id] dropping counts as a single release.
  - A done pulse while in IDLE has no effect.
  - Requests from other requesters during GRANT are not sampled until IDLE.
- Single requester: if only one bit is set and it re-requests after release, it is re-granted; the ptr wrap makes it the last candidate checked, and that candidate is selected.
- Reset mid-grant clears gnt immediately (asynchronous) and restores ptr = 4'hF.

## Timing
- Grant latency: req sampled at edge n while in IDLE → gnt valid after edge n+1. Minimum latency is 1 cycle.
- Release latency: release condition sampled at edge m → gnt = 0 after edge m+1.
- One mandatory idle cycle between grants. The earliest next grant is after edge m+2.
- Back-to-back throughput is one grant per (hold + 2) cycles minimum.
- gnt, gnt_id and gnt_valid are flop outputs with no combinational path from req or done.
- The hold counter is 8 bits and increments once per cycle in GRANT, saturating at 255.

## Configuration
- ARB_TIMEOUT_EN defined:
  - In GRANT, the hold counter reaching HOLD_MAX−1 forces release.
  - The grant therefore lasts at most HOLD_MAX cycles regardless of done or req.
- ARB_TIMEOUT_EN undefined:
  - No hold counter and no forced release.
  - A grant persists until done or until req[gnt_id] drops.
  - The HOLD_MAX parameter is ignored.

## Test plan
- Reset then req = 16'h0001 → gnt = 16'h0001, gnt_id = 0 one cycle later. done pulse → gnt = 0 next cycle; gnt_valid follows.
- req = 16'hFFFF held, done pulsed every grant → gnt_id sequence 0,1,2,…,15,0. Each grant is separated by exactly one idle cycle.
- ptr = 5 (after granting 5), req = 16'h0021 → next winner is 5's successor: gnt_id = 0 (bit 0), not 5. Then 5 is granted next.
- During a grant to 3, drop req[3] with no done → gnt = 0 on the following cycle. Other pending requests are granted one cycle after that.
- With ARB_TIMEOUT_EN, HOLD_MAX = 4, req[7] held and no done → gnt = 16'h0080 for exactly 4 cycles, then idle. Without the macro, the grant stays for 100+ cycles.
- Assert rst mid-grant to 9 → gnt = 0 asynchronously. After release with req = 16'h0201, the winner is 0 (ptr reset to 15).
